// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Grant stage of a round-robin arbiter. It takes the one-hot rotating
//   priority vector from the ring counter and picks one requester, scanning
//   downward from the priority position and wrapping around. The winner gets
//   a registered one-hot grant. The grant is held until the requester drops
//   its request or until MAX_HOLD consecutive cycles have elapsed.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   req      [N]          per-requester request, level-held until served
//   prio     [N]          one-hot priority pointer (sampled only in IDLE)
//   gnt      [N]          registered one-hot grant, all-zero = none
//   gnt_idx  [$clog2(N)]  binary index of the granted requester (valid when busy)
//   busy                  high while a grant is held
//   timeout               one-cycle pulse when a grant is revoked at MAX_HOLD
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         prio,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] hold_cnt;

  logic [IW-1:0] prio_pos;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic          win_found;

  // Priority position: highest set bit of prio; an all-zero prio falls back
  // to N-1 so a malformed pointer still yields a deterministic scan.
  always_comb begin
    prio_pos = IW'(N - 1);
    for (int unsigned i = 0; i < N; i++) begin
      if (prio[i]) prio_pos = IW'(i);
    end
  end

  // Scan p, p-1, ..., 0, N-1, ..., p+1 and take the first requester found.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (int'(prio_pos) + N - k) % N;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_found) begin
            gnt      <= win_oh;
            gnt_idx  <= win_idx;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_idx]) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (hold_cnt == HW'(MAX_HOLD)) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          gnt      <= '0;
          gnt_idx  <= '0;
          busy     <= 1'b0;
          timeout  <= 1'b0;
          hold_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] prio;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         busy;
  logic         timeout;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: "who holds the grant and for how many cycles so far".
  bit m_busy;
  int m_idx;
  int m_held;
  bit m_timeout;

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .prio    (prio),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Rotate the request vector so the priority position sits at the top,
  // then take the highest requesting slot of the rotated view.
  function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] p);
    int pos;
    int order[$];
    pos = N - 1;
    if (p != 0) begin
      for (int i = 0; i < N; i++) if (p[i]) pos = i;
    end
    for (int k = 0; k < N; k++) order.push_back((pos - k + N) % N);
    foreach (order[k]) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_held = 0; m_timeout = 0;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_idx] = 1'b1;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
    if (m_busy) check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(m_idx));
  endtask

  // Drive inputs, advance one clock edge, update the model, compare at +1.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] p, input string tag);
    int w;
    req  = r;
    prio = p;
    @(posedge clk);
    if (!m_busy) begin
      m_timeout = 0;
      w = pick(r, p);
      if (w >= 0) begin
        m_busy = 1; m_idx = w; m_held = 1;
      end
    end else if (!r[m_idx]) begin
      m_busy = 0; m_held = 0;
    end else if (m_held >= MAX_HOLD) begin
      m_busy = 0; m_held = 0; m_timeout = 1;
    end else begin
      m_held++;
    end
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".gnt"}, 32'(gnt), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".timeout"}, 32'(timeout), 32'h0);
    check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'h0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] p;
    reset = 1'b1;
    req   = '0;
    prio  = 4'b0001;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.gnt", 32'(gnt), 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.timeout", 32'(timeout), 32'h0);
    check("reset.gnt_idx", 32'(gnt_idx), 32'h0);
    reset = 1'b0;

    step(4'b0000, 4'b0001, "idle");

    // prio=0100, req=1011 -> idx 1
    step(4'b1011, 4'b0100, "scan_p2");
    check("scan_p2.lit_gnt", 32'(gnt), 32'b0010);
    check("scan_p2.lit_idx", 32'(gnt_idx), 32'd1);
    step(4'b1011, 4'b0100, "hold_a");

    // Reset mid-grant aborts it immediately with no timeout pulse.
    async_reset("mid_reset");
    step(4'b0000, 4'b0001, "after_reset");

    // prio=0001, req=1100 -> wrap to 3
    step(4'b1100, 4'b0001, "wrap");
    check("wrap.lit_gnt", 32'(gnt), 32'b1000);
    check("wrap.lit_idx", 32'(gnt_idx), 32'd3);
    step(4'b0000, 4'b0001, "wrap_rel");
    step(4'b0000, 4'b0001, "idle2");

    // Grant idx 1, hold 3 cycles, release, dead cycle, re-arbitrate.
    step(4'b0010, 4'b0010, "rel_g");
    step(4'b0010, 4'b0010, "rel_h1");
    step(4'b0010, 4'b0010, "rel_h2");
    step(4'b1001, 4'b0010, "rel_drop");
    check("rel_drop.lit_gnt", 32'(gnt), 32'h0);
    step(4'b1001, 4'b1000, "rel_dead");
    step(4'b1001, 4'b1000, "rel_regrant");
    check("rel_regrant.lit_gnt", 32'(gnt), 32'b1000);
    step(4'b0000, 4'b1000, "rel_end");
    step(4'b0000, 4'b1000, "idle3");

    // req[2] held: 8 grant cycles, timeout, dead cycle, re-grant.
    for (int c = 0; c < MAX_HOLD; c++) begin
      step(4'b0100, 4'b0100, "hold8");
      check("hold8.lit_gnt", 32'(gnt), 32'b0100);
    end
    step(4'b0100, 4'b0100, "to");
    check("to.lit_timeout", 32'(timeout), 32'd1);
    check("to.lit_gnt", 32'(gnt), 32'h0);
    step(4'b0100, 4'b0100, "to_regrant");
    check("to_regrant.lit_timeout", 32'(timeout), 32'd0);
    check("to_regrant.lit_gnt", 32'(gnt), 32'b0100);
    step(4'b0000, 4'b0100, "to_end");
    step(4'b0000, 4'b0100, "idle4");

    // Malformed priority vectors.
    step(4'b0001, 4'b0000, "prio_zero");
    check("prio_zero.lit_gnt", 32'(gnt), 32'b0001);
    step(4'b0000, 4'b0000, "pz_rel");
    step(4'b0000, 4'b0000, "idle5");
    step(4'b0111, 4'b0110, "prio_multi");
    check("prio_multi.lit_gnt", 32'(gnt), 32'b0100);
    step(4'b0000, 4'b0110, "pm_rel");

    // Randomized traffic against the model.
    r = '0;
    p = 4'b0001;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) r = N'($urandom);
      if (m_busy && $urandom_range(7) == 0) r[m_idx] = 1'b0;
      if ($urandom_range(9) == 0) p = N'($urandom);
      else p = {p[0], p[N-1:1]};
      if (p == 0 && $urandom_range(1) == 0) p = 4'b0001;
      step(r, p, "rand");
      if ($urandom_range(60) == 0) begin
        async_reset("rand_reset");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
